// File: rtl/canvas_pkg.sv
// Shared types and helpers for the handwrite canvas: streaming FSM states
// and the row-major cell index used by both painting and streaming.
package canvas_pkg;

    localparam int DELTA_W = 9;

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        DONE
    } canvas_state_t;

    function automatic int unsigned cell_idx(input int unsigned x,
                                             input int unsigned y,
                                             input int unsigned w);
        return y * w + x;
    endfunction

endpackage

// File: rtl/canvas_axis.sv
// One cursor axis: saturating fixed-point accumulator of signed mouse deltas,
// exposing both the registered cell and the cell it will hold after this cycle.
module canvas_axis
    import canvas_pkg::*;
#(
    parameter int CELLS      = 30,
    parameter int MOVE_SHIFT = 2,
    localparam int CW        = $clog2(CELLS)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic signed [DELTA_W-1:0] delta,
    input  logic                      negate,
    input  logic                      strobe,
    output logic [CW-1:0]             cell_o,
    output logic [CW-1:0]             cell_next_o
);

    localparam int FPW = CW + MOVE_SHIFT;
    // Two spare bits above the wider operand: one for sign, one for carry.
    localparam int SW  = ((FPW > DELTA_W) ? FPW : DELTA_W) + 2;

    localparam logic [FPW-1:0]       FP_MAX     = FPW'(CELLS * (1 << MOVE_SHIFT) - 1);
    localparam logic [FPW-1:0]       FP_RST     = FPW'((CELLS / 2) << MOVE_SHIFT);
    localparam logic signed [SW-1:0] FP_MAX_EXT = SW'(CELLS * (1 << MOVE_SHIFT) - 1);

    logic [FPW-1:0]       fp_q, fp_d;
    logic signed [SW-1:0] fp_ext, d_ext, sum;

    assign fp_ext = $signed({{(SW - FPW){1'b0}}, fp_q});
    assign d_ext  = {{(SW - DELTA_W){delta[DELTA_W-1]}}, delta};
    assign sum    = negate ? (fp_ext - d_ext) : (fp_ext + d_ext);

    always_comb begin
        fp_d = fp_q;
        if (strobe) begin
            if (sum[SW-1]) begin
                fp_d = '0;
            end else if (sum > FP_MAX_EXT) begin
                fp_d = FP_MAX;
            end else begin
                fp_d = sum[FPW-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fp_q <= FP_RST;
        end else begin
            fp_q <= fp_d;
        end
    end

    assign cell_o      = fp_q[FPW-1 -: CW];
    assign cell_next_o = fp_d[FPW-1 -: CW];

endmodule

// File: rtl/handwrite_canvas.sv
// Mouse-driven paint canvas with full-bitmap output and a back-pressured
// row-major pixel stream toward the digit classifier.
//
// state  | meaning
// IDLE   | canvas writable, waiting for i_send
// STREAM | presenting cell idx on the pixel interface; canvas frozen
// DONE   | one-cycle completion pulse; canvas still frozen
module handwrite_canvas
    import canvas_pkg::*;
#(
    parameter int CANVAS_W   = 30,
    parameter int CANVAS_H   = 30,
    parameter int PIX_W      = 8,
    parameter int MOVE_SHIFT = 2,
    localparam int XW        = $clog2(CANVAS_W),
    localparam int YW        = $clog2(CANVAS_H),
    localparam int NCELL     = CANVAS_W * CANVAS_H
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic signed [DELTA_W-1:0] i_mouse_dx,
    input  logic signed [DELTA_W-1:0] i_mouse_dy,
    input  logic                      i_lmb,
    input  logic                      i_rmb,
    input  logic                      i_mouse_valid,
    input  logic                      i_clear,
    input  logic                      i_send,
    input  logic                      i_pixel_ready,
    output logic [NCELL-1:0]          o_canvas,
    output logic [XW-1:0]             o_cursor_x,
    output logic [YW-1:0]             o_cursor_y,
    output logic [PIX_W-1:0]          o_pixel,
    output logic                      o_pixel_valid,
    output logic                      o_busy,
    output logic                      o_done
);

    localparam int IW = $clog2(NCELL);
    localparam logic [IW-1:0] LAST_IDX = IW'(NCELL - 1);

    canvas_state_t    state_q, state_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [NCELL-1:0] canvas_q, canvas_d;
    logic [XW-1:0]    x_next;
    logic [YW-1:0]    y_next;
    logic [IW-1:0]    widx;

    canvas_axis #(.CELLS(CANVAS_W), .MOVE_SHIFT(MOVE_SHIFT)) u_axis_x (
        .clk         (clk),
        .rst         (rst),
        .delta       (i_mouse_dx),
        .negate      (1'b0),
        .strobe      (i_mouse_valid),
        .cell_o      (o_cursor_x),
        .cell_next_o (x_next)
    );

    // Mouse Y is positive upward, canvas rows grow downward.
    canvas_axis #(.CELLS(CANVAS_H), .MOVE_SHIFT(MOVE_SHIFT)) u_axis_y (
        .clk         (clk),
        .rst         (rst),
        .delta       (i_mouse_dy),
        .negate      (1'b1),
        .strobe      (i_mouse_valid),
        .cell_o      (o_cursor_y),
        .cell_next_o (y_next)
    );

    assign widx = IW'(cell_idx(32'(x_next), 32'(y_next), 32'(CANVAS_W)));

    always_comb begin
        canvas_d = canvas_q;
        if (state_q == IDLE) begin
            if (i_clear) begin
                canvas_d = '0;
            end else if (i_mouse_valid && i_lmb) begin
                canvas_d[widx] = 1'b1;
            end else if (i_mouse_valid && i_rmb) begin
                canvas_d[widx] = 1'b0;
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        o_pixel       = '0;
        o_pixel_valid = 1'b0;
        o_busy        = 1'b0;
        o_done        = 1'b0;
        case (state_q)
            IDLE: begin
                if (i_send) begin
                    state_d = STREAM;
                    idx_d   = '0;
                end
            end
            STREAM: begin
                o_busy        = 1'b1;
                o_pixel_valid = 1'b1;
                o_pixel       = {PIX_W{canvas_q[idx_q]}};
                if (i_pixel_ready) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = DONE;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            DONE: begin
                o_done  = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            canvas_q <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            canvas_q <= canvas_d;
        end
    end

    assign o_canvas = canvas_q;

endmodule

// File: tb/tb_handwrite_canvas.sv
// Directed bench for handwrite_canvas: expected pixels and completion latencies
// are queued at stimulus time and popped by an independent monitor.
module tb_handwrite_canvas;

    localparam int NC = 900;

    logic              clk = 1'b0;
    logic              rst;
    logic signed [8:0] dx, dy;
    logic              lmb, rmb, mv, clr, send, ready;
    logic [NC-1:0]     canvas;
    logic [4:0]        cx, cy;
    logic [7:0]        pixel;
    logic              pv, busy, done;

    int            checks   = 0;
    int            failures = 0;
    int            cyc      = 0;
    int            t_send   = 0;
    logic [7:0]    exp_pix[$];
    int            exp_lat[$];
    logic [NC-1:0] model;
    logic [NC-1:0] expv;
    logic [7:0]    e;
    int            lat;
    logic          pv_prev;

    handwrite_canvas dut (
        .clk           (clk),
        .rst           (rst),
        .i_mouse_dx    (dx),
        .i_mouse_dy    (dy),
        .i_lmb         (lmb),
        .i_rmb         (rmb),
        .i_mouse_valid (mv),
        .i_clear       (clr),
        .i_send        (send),
        .i_pixel_ready (ready),
        .o_canvas      (canvas),
        .o_cursor_x    (cx),
        .o_cursor_y    (cy),
        .o_pixel       (pixel),
        .o_pixel_valid (pv),
        .o_busy        (busy),
        .o_done        (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: compare every handshake, every stalled beat and every done pulse.
    always @(negedge clk) begin
        pv_prev <= pv;
        if (pv === 1'b1 && pv_prev === 1'b0 && rst === 1'b0) begin
            checks++;
            if (cyc != t_send + 1) begin
                failures++;
                $display("FAIL first_beat_time actual=%0d required=%0d", cyc - t_send, 1);
            end
        end
        if (pv === 1'b1 && ready === 1'b1) begin
            checks++;
            if (exp_pix.size() == 0) begin
                failures++;
                $display("FAIL beat_extra actual=pixel %0h required=no beat", pixel);
            end else begin
                e = exp_pix.pop_front();
                if (pixel !== e) begin
                    failures++;
                    $display("FAIL beat_%0d actual=%0h required=%0h", NC - exp_pix.size() - 1, pixel, e);
                end
            end
        end else if (pv === 1'b1 && ready === 1'b0 && exp_pix.size() > 0) begin
            checks++;
            if (pixel !== exp_pix[0]) begin
                failures++;
                $display("FAIL stall_hold actual=%0h required=%0h", pixel, exp_pix[0]);
            end
        end
        if (done === 1'b1) begin
            checks++;
            if (exp_lat.size() == 0) begin
                failures++;
                $display("FAIL done_spurious actual=1 required=0");
            end else begin
                lat = exp_lat.pop_front();
                if (cyc - t_send != lat || busy !== 1'b0) begin
                    failures++;
                    $display("FAIL done_latency actual=%0d busy=%0b required=%0d busy=0",
                             cyc - t_send, busy, lat);
                end
            end
        end
    end

    task automatic chk(input string nm, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, req);
        end
    endtask

    task automatic chk_canvas(input string nm, input logic [NC-1:0] req);
        checks++;
        if (canvas !== req) begin
            failures++;
            $display("FAIL %s actual_ones=%0d required_ones=%0d differing_bits=%0d",
                     nm, $countones(canvas), $countones(req), $countones(canvas ^ req));
        end
    endtask

    task automatic mouse(input int dx_v, input int dy_v, input logic l, input logic r, input logic c);
        @(posedge clk); #1;
        dx = 9'(dx_v); dy = 9'(dy_v); lmb = l; rmb = r; clr = c; mv = 1'b1;
        @(posedge clk); #1;
        dx = '0; dy = '0; lmb = 1'b0; rmb = 1'b0; clr = 1'b0; mv = 1'b0;
        @(negedge clk);
    endtask

    task automatic push_stream(input int beats, input int latency);
        for (int i = 0; i < beats; i++) exp_pix.push_back(model[i] ? 8'hFF : 8'h00);
        if (latency > 0) exp_lat.push_back(latency);
    endtask

    task automatic start_stream();
        @(posedge clk); #1;
        send = 1'b1;
        @(negedge clk);
        t_send = cyc;
        @(posedge clk); #1;
        send = 1'b0;
    endtask

    task automatic wait_done(input string nm);
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            if (done === 1'b1) break;
        end
        chk(nm, int'(done), 1);
    endtask

    initial begin
        rst = 1'b1; dx = '0; dy = '0; lmb = 1'b0; rmb = 1'b0;
        mv = 1'b0; clr = 1'b0; send = 1'b0; ready = 1'b1;
        model = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);

        chk("rst_cx", int'(cx), 15);
        chk("rst_cy", int'(cy), 15);
        chk("rst_valid", int'(pv), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_pixel", int'(pixel), 0);
        chk_canvas("rst_canvas", '0);

        mouse(8, 0, 1'b1, 1'b0, 1'b0);
        chk("move_cx", int'(cx), 17);
        chk("move_cy", int'(cy), 15);
        expv = '0; expv[467] = 1'b1;
        chk_canvas("paint_467", expv);

        for (int i = 0; i < 20; i++) mouse(255, 0, 1'b0, 1'b0, 1'b0);
        chk("sat_cx_hi", int'(cx), 29);
        chk("sat_xfp_hi", int'(dut.u_axis_x.fp_q), 119);
        mouse(-256, 0, 1'b0, 1'b0, 1'b0);
        chk("sat_cx_lo", int'(cx), 0);
        chk("sat_xfp_lo", int'(dut.u_axis_x.fp_q), 0);
        mouse(-256, 0, 1'b0, 1'b0, 1'b0);
        chk("sat_cx_lo2", int'(cx), 0);
        mouse(0, -255, 1'b0, 1'b0, 1'b0);
        chk("sat_cy_hi", int'(cy), 29);
        mouse(0, -255, 1'b0, 1'b0, 1'b0);
        chk("sat_yfp_hi", int'(dut.u_axis_y.fp_q), 119);
        mouse(0, 255, 1'b0, 1'b0, 1'b0);
        chk("sat_cy_lo", int'(cy), 0);
        mouse(0, 255, 1'b0, 1'b0, 1'b0);
        chk("sat_cy_lo2", int'(cy), 0);
        chk_canvas("move_keeps_canvas", expv);

        mouse(4, 0, 1'b1, 1'b0, 1'b0);
        expv[1] = 1'b1;
        chk_canvas("paint_1", expv);
        mouse(0, 0, 1'b0, 1'b1, 1'b0);
        expv[1] = 1'b0;
        chk_canvas("erase_1", expv);
        mouse(0, 0, 1'b1, 1'b1, 1'b0);
        expv[1] = 1'b1;
        chk_canvas("both_paint_wins", expv);
        mouse(0, 0, 1'b0, 1'b1, 1'b0);
        mouse(-4, 0, 1'b0, 1'b0, 1'b0);
        chk("back_cx", int'(cx), 0);
        mouse(0, 0, 1'b1, 1'b0, 1'b1);
        chk_canvas("clear_beats_paint", '0);

        // Stream 1: only cell 0 set, ready always high, stray i_send mid-stream.
        mouse(0, 0, 1'b1, 1'b0, 1'b0);
        model[0] = 1'b1;
        push_stream(NC, 901);
        start_stream();
        repeat (300) @(posedge clk);
        #1 send = 1'b1;
        @(posedge clk); #1 send = 1'b0;
        @(negedge clk);
        chk("busy_mid", int'(busy), 1);
        wait_done("done1");
        chk_canvas("after_stream1", model);

        // Stream 2: cells 0 and 10, five-cycle stall on beat 10, writes ignored.
        mouse(40, 0, 1'b1, 1'b0, 1'b0);
        model[10] = 1'b1;
        chk("cx_10", int'(cx), 10);
        push_stream(NC, 906);
        start_stream();
        repeat (10) @(posedge clk);
        #1 ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 dx = 9'sd4; lmb = 1'b1; mv = 1'b1;
        @(posedge clk);
        #1 dx = '0; lmb = 1'b0; mv = 1'b0;
        repeat (2) @(posedge clk);
        #1 ready = 1'b1;
        repeat (50) @(posedge clk);
        #1 clr = 1'b1;
        @(posedge clk); #1 clr = 1'b0;
        wait_done("done2");
        chk_canvas("frozen_canvas", model);
        chk("cx_moved_in_stream", int'(cx), 11);
        chk("cy_moved_in_stream", int'(cy), 0);

        // Stream 3: reset lands while beat 400 is handshaking.
        push_stream(401, 0);
        start_stream();
        repeat (400) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        model = '0;
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_valid", int'(pv), 0);
        chk("midrst_done", int'(done), 0);
        chk("midrst_cx", int'(cx), 15);
        chk("midrst_cy", int'(cy), 15);
        chk_canvas("midrst_canvas", '0);
        repeat (20) @(negedge clk);
        chk("beats_left", exp_pix.size(), 0);
        chk("dones_left", exp_lat.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/handwrite_canvas.md
# handwrite_canvas

Parametrised drawing canvas between the PS/2 mouse decoder and the digit CNN. It accumulates mouse movement into a saturating cursor and paints or erases canvas cells with the buttons. It exposes the full bitmap for VGA overlay and, on request, streams the bitmap row-major to the CNN over a valid/ready pixel interface. It generalises the fixed 30x30 handwrite bitmap to any canvas size, adds sub-cell movement scaling and an erase mode, and adds a back-pressured streaming engine.

## Interface
- CANVAS_W, 30: canvas width in cells
- CANVAS_H, 30: canvas height in cells
- PIX_W, 8: width of streamed pixel
- MOVE_SHIFT, 2: mouse counts per cell = 2^MOVE_SHIFT
- clk  in  1  system clock (25 MHz domain)
- rst  in  1  reset; one clock, synchronous, active-high
- i_mouse_dx  in  9  signed two's-complement X movement, +right
- i_mouse_dy  in  9  signed two's-complement Y movement, +up
- i_lmb  in  1  left button, paint
- i_rmb  in  1  right button, erase
- i_mouse_valid  in  1  one-cycle strobe qualifying dx/dy/buttons
- i_clear  in  1  clear whole canvas
- i_send  in  1  start streaming
- i_pixel_ready  in  1  CNN accepts pixel
- o_canvas  out  CANVAS_W*CANVAS_H  bitmap; bit index = y*CANVAS_W+x
- o_cursor_x  out  $clog2(CANVAS_W)  cursor cell column
- o_cursor_y  out  $clog2(CANVAS_H)  cursor cell row
- o_pixel  out  PIX_W  streamed pixel: all-ones if cell set, else 0
- o_pixel_valid  out  1  o_pixel valid
- o_busy  out  1  stream in progress
- o_done  out  1  one-cycle pulse after last pixel accepted

## Operation
- Cursor is held in fixed point: x_fp has $clog2(CANVAS_W)+MOVE_SHIFT bits; y_fp is sized the same way from CANVAS_H. The cursor cell is the fixed-point value >> MOVE_SHIFT.
- On i_mouse_valid:
  - x_fp <= sat(x_fp + sext(dx)).
  - y_fp <= sat(y_fp - sext(dy)), because screen Y points down.
  - sat clamps to [0, CANVAS_W*2^MOVE_SHIFT-1] for X and [0, CANVAS_H*2^MOVE_SHIFT-1] for Y.
  - Compute the sum one bit wider and signed, so there is no wrap-around.
- Paint/erase on the same i_mouse_valid, applied to the cell at the updated cursor position:
  - i_lmb sets the cell.
  - i_rmb (without i_lmb) clears the cell.
  - If both buttons are pressed, paint wins.
- i_clear zeroes all cells. If i_clear coincides with paint/erase, clear wins.
- FSM (state type in package): IDLE, STREAM, DONE.
  - IDLE: i_send moves to STREAM and sets idx=0.
  - STREAM: o_pixel_valid=1; o_pixel = o_canvas[idx] ? '1 : '0. On valid&ready: if idx==CANVAS_W*CANVAS_H-1 go to DONE, else idx++. While not ready, o_pixel and idx hold.
  - DONE: o_done=1 for one cycle, then IDLE.
- o_busy = (state==STREAM).
- While not IDLE, canvas writes and i_clear are ignored, so the snapshot is stable. Cursor movement continues.
- i_send outside IDLE is ignored.
- i_send together with paint in IDLE: the paint lands, and the stream sees the painted cell.
- rst mid-stream: immediately returns to IDLE and applies the reset values; no o_done is produced.

## Timing
- Reset values:
  - canvas all 0
  - x_fp = (CANVAS_W/2)<<MOVE_SHIFT and y_fp = (CANVAS_H/2)<<MOVE_SHIFT, i.e. cursor (15,15) at defaults
  - o_pixel=0, o_pixel_valid=0, o_busy=0, o_done=0, state IDLE
- Cursor and canvas outputs update one cycle after i_mouse_valid.
- i_send at cycle t gives o_pixel_valid=1 with pixel 0 at t+1.
- With ready held high, beat n is transferred at t+1+n.
- With the final handshake at cycle k, o_done=1 and o_busy=0 at k+1. The next i_send is accepted from k+2.
- Total stream length with no back-pressure: CANVAS_W*CANVAS_H cycles.

## Structure
- Package canvas_pkg: state enum canvas_state_t (IDLE, STREAM, DONE) and the helper function for cell-index computation.
- Sub-module canvas_axis, instantiated twice (X and Y):
  - parameters CELLS, MOVE_SHIFT; input signed delta, negate flag, strobe
  - saturating fixed-point accumulator; outputs cell index

## Test plan
- Reset, then dx=+8, dy=0, lmb=1, valid -> cursor (17,15); o_canvas bit 467 = 1, all other bits 0.
- Twenty strobes of dx=+255 -> cursor x saturates at 29 (x_fp=119). Then dx=-256 repeated -> x=0, with no wrap. dy=+255 repeated -> y=0.
- Paint (0,0), then i_send with ready=1 -> 900 beats: beat 0 = 255, others 0; o_done exactly 901 cycles after i_send; o_busy low in that same cycle.
- Ready low for 5 cycles at beat 10 -> o_pixel and o_pixel_valid held stable, idx does not advance; total beat count stays 900.
- Paint requested during STREAM, and i_clear during STREAM -> canvas unchanged until DONE. i_clear together with lmb in IDLE -> all zero.
- rst asserted at beat 400 -> next cycle o_busy=0, o_pixel_valid=0, canvas 0, cursor (15,15); no o_done pulse.
